div32appx_seq: RTL and testbench

- Approximate divider: dividend divided by divisor, with the divisor rounded to the nearest power of two; the division is a right shift.
- Inverse of the team's approximate-multiply unit. Same rounding thresholds (3·2^j), opposite shift direction.
- Sequential threshold scan (one compare per cycle) keeps area small; valid/ready on both sides.
- Sits in the functional-unit array beside the approximate multipliers.

---
 rtl/div_appx_pkg.sv | 23 ++
 rtl/appx_shift_sat.sv | 33 +++
 rtl/div32appx_seq.sv | 134 +++++++++++++
 tb/tb_div32appx_seq.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/div_appx_pkg.sv
// Shared constants, FSM state type and threshold helper for the approximate divider.
package div_appx_pkg;

    localparam int unsigned DEF_DIVIDEND_W = 32;
    localparam int unsigned DEF_DIVISOR_W  = 16;
    localparam int unsigned DEF_QUOT_W     = 16;
    localparam int unsigned SHIFT_W        = 5;

    localparam logic [DEF_QUOT_W-1:0] QMAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_CALC = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Rounding threshold 3*2^j: divisors at or above it round up to 2^(j+2).
    function automatic logic [31:0] thresh(input logic [SHIFT_W-1:0] j);
        return 32'(3) << j;
    endfunction

endpackage

// File: rtl/appx_shift_sat.sv
// Right shift of the dividend by k with saturation to the quotient width.
// Define DIV32APPX_ROUND_EN to round half up before the shift.
module appx_shift_sat
    import div_appx_pkg::*;
#(
    parameter int unsigned DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int unsigned QUOT_W     = DEF_QUOT_W
) (
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [SHIFT_W-1:0]    k,
    output logic [QUOT_W-1:0]     quot_c,
    output logic                  sat_c
);

    localparam int unsigned SUM_W = DIVIDEND_W + 1;

    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] q;

    // One extra bit so the rounding carry is kept and feeds saturation.
    always_comb begin
        sum = SUM_W'(dividend);
`ifdef DIV32APPX_ROUND_EN
        if (k != '0) begin
            sum = sum + (SUM_W'(1) << (k - SHIFT_W'(1)));
        end
`endif
        q      = sum >> k;
        sat_c  = |(q >> QUOT_W);
        quot_c = sat_c ? '1 : q[QUOT_W-1:0];
    end

endmodule

// File: rtl/div32appx_seq.sv
// Approximate divider: divisor rounded to nearest power of two, found by a serial threshold scan.
// Optional round-half-up of the quotient under DIV32APPX_ROUND_EN (see appx_shift_sat).
module div32appx_seq
    import div_appx_pkg::*;
#(
    parameter int unsigned DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int unsigned DIVISOR_W  = DEF_DIVISOR_W,
    parameter int unsigned QUOT_W     = DEF_QUOT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] in_dividend,
    input  logic [DIVISOR_W-1:0]  in_divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [QUOT_W-1:0]     out_quot,
    output logic [SHIFT_W-1:0]    out_shift,
    output logic                  out_dz,
    output logic                  out_sat
);

    localparam logic [SHIFT_W-1:0] J_START = SHIFT_W'(DIVISOR_W - 2);

    state_e                state, state_n;
    logic [SHIFT_W-1:0]    j, j_n;
    logic [SHIFT_W-1:0]    k, k_n;
    logic                  dz, dz_n;
    logic [DIVIDEND_W-1:0] dividend, dividend_n;
    logic [DIVISOR_W-1:0]  divisor, divisor_n;
    logic                  in_ready_n, out_valid_n;
    logic [QUOT_W-1:0]     out_quot_n;
    logic [SHIFT_W-1:0]    out_shift_n;
    logic                  out_dz_n, out_sat_n;
    logic [QUOT_W-1:0]     calc_quot;
    logic                  calc_sat;

    appx_shift_sat #(
        .DIVIDEND_W (DIVIDEND_W),
        .QUOT_W     (QUOT_W)
    ) u_shift_sat (
        .dividend (dividend),
        .k        (k),
        .quot_c   (calc_quot),
        .sat_c    (calc_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            j         <= '0;
            k         <= '0;
            dz        <= 1'b0;
            dividend  <= '0;
            divisor   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_quot  <= '0;
            out_shift <= '0;
            out_dz    <= 1'b0;
            out_sat   <= 1'b0;
        end else begin
            state     <= state_n;
            j         <= j_n;
            k         <= k_n;
            dz        <= dz_n;
            dividend  <= dividend_n;
            divisor   <= divisor_n;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
            out_quot  <= out_quot_n;
            out_shift <= out_shift_n;
            out_dz    <= out_dz_n;
            out_sat   <= out_sat_n;
        end
    end

    always_comb begin
        state_n     = state;
        j_n         = j;
        k_n         = k;
        dz_n        = dz;
        dividend_n  = dividend;
        divisor_n   = divisor;
        out_quot_n  = out_quot;
        out_shift_n = out_shift;
        out_dz_n    = out_dz;
        out_sat_n   = out_sat;

        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    dividend_n = in_dividend;
                    divisor_n  = in_divisor;
                    j_n        = J_START;
                    k_n        = '0;
                    dz_n       = 1'b0;
                    state_n    = ST_SCAN;
                end
            end
            // One threshold compare per cycle, walking down from the top.
            ST_SCAN: begin
                if (32'(divisor) >= thresh(j)) begin
                    k_n     = j + SHIFT_W'(2);
                    state_n = ST_CALC;
                end else if (j == '0) begin
                    k_n     = (divisor == DIVISOR_W'(2)) ? SHIFT_W'(1) : SHIFT_W'(0);
                    dz_n    = (divisor == '0);
                    state_n = ST_CALC;
                end else begin
                    j_n = j - SHIFT_W'(1);
                end
            end
            ST_CALC: begin
                out_quot_n  = dz ? '1 : calc_quot;
                out_shift_n = dz ? '0 : k;
                out_sat_n   = dz ? 1'b0 : calc_sat;
                out_dz_n    = dz;
                state_n     = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        in_ready_n  = (state_n == ST_IDLE);
        out_valid_n = (state_n == ST_DONE);
    end

endmodule

// File: tb/tb_div32appx_seq.sv
// Directed self-checking bench for div32appx_seq; expectations follow DIV32APPX_ROUND_EN.
module tb_div32appx_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_dividend;
    logic [15:0] in_divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_quot;
    logic [4:0]  out_shift;
    logic        out_dz;
    logic        out_sat;

    int total  = 0;
    int passed = 0;
    int lat;
    bit seen_valid;

`ifdef DIV32APPX_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    div32appx_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_dividend (in_dividend),
        .in_divisor  (in_divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_quot    (out_quot),
        .out_shift   (out_shift),
        .out_dz      (out_dz),
        .out_sat     (out_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Issue one request and count edges from accept until out_valid (bounded).
    task automatic issue(input logic [31:0] dvd, input logic [15:0] dvs, output int latency);
        @(negedge clk);
        in_valid    = 1'b1;
        in_dividend = dvd;
        in_divisor  = dvs;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        latency  = 0;
        while (!out_valid && latency < 40) begin
            @(posedge clk);
            latency++;
            @(negedge clk);
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_case(input string tag, input logic [31:0] dvd, input logic [15:0] dvs,
                            input int exp_lat, input logic [15:0] exp_q, input logic [4:0] exp_k,
                            input logic exp_dz, input logic exp_sat);
        int l;
        issue(dvd, dvs, l);
        chk({tag, "_lat"},   64'(l),         64'(exp_lat));
        chk({tag, "_quot"},  64'(out_quot),  64'(exp_q));
        chk({tag, "_shift"}, 64'(out_shift), 64'(exp_k));
        chk({tag, "_dz"},    64'(out_dz),    64'(exp_dz));
        chk({tag, "_sat"},   64'(out_sat),   64'(exp_sat));
        handshake();
        chk({tag, "_vld_drop"}, 64'(out_valid), 64'(0));
        chk({tag, "_rdy_back"}, 64'(in_ready),  64'(1));
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        out_ready   = 1'b0;
        #12;
        chk("rst_in_ready",  64'(in_ready),  64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_quot",  64'(out_quot),  64'(0));
        chk("rst_out_shift", 64'(out_shift), 64'(0));
        chk("rst_flags",     64'({out_dz, out_sat}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // 0x1000 / 4 -> k=2, slowest scan, then hold under backpressure
        issue(32'h0000_1000, 16'd4, lat);
        chk("div4_lat",   64'(lat),       64'(16));
        chk("div4_quot",  64'(out_quot),  64'h400);
        chk("div4_shift", 64'(out_shift), 64'(2));
        chk("div4_flags", 64'({out_dz, out_sat}), 64'(0));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_valid",    64'(out_valid), 64'(1));
            chk("bp_in_ready", 64'(in_ready),  64'(0));
            chk("bp_quot",     64'(out_quot),  64'h400);
            chk("bp_shift",    64'(out_shift), 64'(2));
        end
        handshake();
        chk("hs_valid_drop", 64'(out_valid), 64'(0));
        chk("hs_in_ready",   64'(in_ready),  64'(1));
        chk("hs_quot_kept",  64'(out_quot),  64'h400);

        run_case("big",   32'h8000_0000, 16'd49152, 2,  16'h8000, 5'd16, 1'b0, 1'b0);
        run_case("one",   32'h0012_3456, 16'd1,     16, 16'hFFFF, 5'd0,  1'b0, 1'b1);
        run_case("zero",  32'hDEAD_BEEF, 16'd0,     16, 16'hFFFF, 5'd0,  1'b1, 1'b0);
        run_case("seven", 32'd7,         16'd4,     16, ROUND ? 16'd2 : 16'd1, 5'd2, 1'b0, 1'b0);
        run_case("six",   32'd800,       16'd6,     15, 16'd100,  5'd3,  1'b0, 1'b0);
        run_case("five",  32'd800,       16'd5,     16, 16'd200,  5'd2,  1'b0, 1'b0);
        run_case("two",   32'h0001_FFFF, 16'd2,     16, 16'hFFFF, 5'd1,  1'b0, ROUND);
        run_case("ffff",  32'hFFFF_FFFF, 16'hFFFF,  2,  16'hFFFF, 5'd16, 1'b0, ROUND);
        run_case("49151", 32'h0001_0000, 16'd49151, 3,  16'd2,    5'd15, 1'b0, 1'b0);

        // Reset during SCAN: outputs cleared and no result afterwards
        @(negedge clk);
        in_valid    = 1'b1;
        in_dividend = 32'h0000_1000;
        in_divisor  = 16'd4;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_in_ready",  64'(in_ready),  64'(1));
        chk("mrst_out_valid", 64'(out_valid), 64'(0));
        chk("mrst_out_quot",  64'(out_quot),  64'(0));
        chk("mrst_out_shift", 64'(out_shift), 64'(0));
        chk("mrst_flags",     64'({out_dz, out_sat}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        chk("mrst_no_stale", 64'(seen_valid), 64'(0));
        chk("mrst_idle_rdy", 64'(in_ready),   64'(1));

        run_case("post", 32'h0000_0100, 16'd16, 14, 16'd16, 5'd4, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
